// File: rtl/mvm_stream_acc.sv
// Weight-streaming matrix-vector multiplier: y = W*x with a latched activation
// vector, row-major weight stream under valid/ready, optional signed mode and ReLU.
module mvm_stream_acc #(
  parameter int unsigned N_IN  = 4,
  parameter int unsigned N_OUT = 4,
  parameter int unsigned XW    = 4,
  parameter int unsigned WW    = 4,
  parameter int unsigned ACCW  = 16
) (
  input  logic                    i_clk_mvm,
  input  logic                    i_rst_mvm,
  input  logic                    i_start_mvm,
  input  logic                    i_signed_mvm,
  input  logic                    i_relu_mvm,
  input  logic [N_IN*XW-1:0]      i_x_bn,
  input  logic [WW-1:0]           i_w_mvm,
  input  logic                    i_w_valid_mvm,
  output logic                    o_w_ready_mvm,
  output logic                    o_ismvm,
  output logic                    o_done_mvm,
  output logic [N_OUT*ACCW-1:0]   o_wx_result
);

  localparam int unsigned CW = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int unsigned RW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(N_IN - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(N_OUT - 1);

  if (ACCW < XW + WW + $clog2(N_IN)) begin : g_accw_check
    $error("mvm_stream_acc: ACCW too narrow for XW+WW+clog2(N_IN)");
  end

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [N_IN*XW-1:0]      r_x;
  logic                    r_sgn;
  logic                    r_relu;
  logic [CW-1:0]           r_col;
  logic [RW-1:0]           r_row;
  logic [ACCW-1:0]         r_acc [N_OUT];
  logic [N_OUT*ACCW-1:0]   r_res;
  logic                    r_done;

  logic                    w_accept;
  logic                    w_last;
  logic [XW-1:0]           w_xsel;
  logic signed [XW:0]      w_xs;
  logic signed [WW:0]      w_ws;
  logic signed [XW+WW+1:0] w_prod;
  logic [ACCW-1:0]         w_prod_ext;

  assign w_accept = (r_state == RUN) && i_w_valid_mvm;
  assign w_last   = w_accept && (r_row == ROW_LAST) && (r_col == COL_LAST);

  // One extra top bit per operand lets a single signed multiplier serve both
  // modes: it copies the sign bit in signed mode and is zero in unsigned mode.
  assign w_xsel     = r_x[r_col*XW +: XW];
  assign w_xs       = $signed({r_sgn & w_xsel[XW-1], w_xsel});
  assign w_ws       = $signed({r_sgn & i_w_mvm[WW-1], i_w_mvm});
  assign w_prod     = w_xs * w_ws;
  assign w_prod_ext = ACCW'(w_prod);

  always_ff @(posedge i_clk_mvm or posedge i_rst_mvm) begin
    if (i_rst_mvm) r_state <= IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    o_w_ready_mvm = 1'b0;
    o_ismvm       = 1'b0;
    case (r_state)
      IDLE: if (i_start_mvm) w_next = RUN;
      RUN: begin
        o_w_ready_mvm = 1'b1;
        o_ismvm       = 1'b1;
        if (w_last) w_next = FIN;
      end
      FIN: begin
        o_ismvm = 1'b1;
        w_next  = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk_mvm or posedge i_rst_mvm) begin
    if (i_rst_mvm) begin
      r_x    <= '0;
      r_sgn  <= 1'b0;
      r_relu <= 1'b0;
      r_col  <= '0;
      r_row  <= '0;
      r_res  <= '0;
      r_done <= 1'b0;
      for (int unsigned i = 0; i < N_OUT; i++) r_acc[i] <= '0;
    end else begin
      r_done <= (r_state == FIN);
      case (r_state)
        IDLE: begin
          if (i_start_mvm) begin
            r_x    <= i_x_bn;
            r_sgn  <= i_signed_mvm;
            r_relu <= i_relu_mvm;
            r_col  <= '0;
            r_row  <= '0;
            for (int unsigned i = 0; i < N_OUT; i++) r_acc[i] <= '0;
          end
        end
        RUN: begin
          if (w_accept) begin
            r_acc[r_row] <= r_acc[r_row] + w_prod_ext;
            if (r_col == COL_LAST) begin
              r_col <= '0;
              r_row <= r_row + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        FIN: begin
          for (int unsigned i = 0; i < N_OUT; i++) begin
            if (r_sgn && r_relu && r_acc[i][ACCW-1]) r_res[i*ACCW +: ACCW] <= '0;
            else                                     r_res[i*ACCW +: ACCW] <= r_acc[i];
          end
        end
        default: ;
      endcase
    end
  end

  assign o_done_mvm  = r_done;
  assign o_wx_result = r_res;

endmodule
